valid_to_ready_fifo: RTL and testbench

Downstream stage for the valid-only delay and formula pipelines: accepts a transfer stream that has no backpressure (`in_vld`/`in_data`) and presents it to a consumer through a valid/ready handshake. It buffers up to `depth` transfers in first-word-fall-through order. Transfers that arrive while it is full are dropped and flagged. It sits between the last pipeline or shift-register stage of a formula pipe and any consumer that can stall.

---
 rtl/valid_fifo_pkg.sv | 13 +
 rtl/valid_fifo_ptr.sv | 23 ++
 rtl/valid_to_ready_fifo.sv | 99 +++++++++
 tb/tb_valid_to_ready_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/valid_fifo_pkg.sv
// Shared constants and helpers for the valid-to-ready FIFO.
// The optional drop counter is enabled with the VALID_FIFO_DROP_CNT_EN macro.
package valid_fifo_pkg;

  localparam int unsigned DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // Pointer width for a given depth. Never returns less than 1 bit.
  function automatic int unsigned ptr_width(input int unsigned d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/valid_fifo_ptr.sv
// Wrapping pointer counter for the valid-to-ready FIFO.
// Depth is a power of two, so natural overflow of the register gives the modulo wrap.
module valid_fifo_ptr
  import valid_fifo_pkg::*;
#(
  parameter int unsigned depth = 8,
  localparam int unsigned PW = ptr_width(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/valid_to_ready_fifo.sv
// First-word-fall-through buffer that turns a valid-only stream into valid/ready.
// Writes arriving while full are dropped; VALID_FIFO_DROP_CNT_EN adds a saturating drop counter.
module valid_to_ready_fifo
  import valid_fifo_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [width-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [width-1:0] out_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
`ifdef VALID_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int unsigned PW = ptr_width(depth);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [width-1:0] mem [depth];
  logic             push;
  logic             pop;
  logic             drop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    out_vld = !empty;
    pop     = out_vld & out_rdy;
    // A full buffer still accepts a write when the head is popped in the same cycle.
    push    = in_vld & (!full | pop);
    drop    = in_vld & full & !pop;
  end

  assign out_data = mem[rd_ptr];

  valid_fifo_ptr #(.depth(depth)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  valid_fifo_ptr #(.depth(depth)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef VALID_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != DROP_CNT_MAX)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_valid_to_ready_fifo.sv
// Bench for valid_to_ready_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_valid_to_ready_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

  logic             clk;
  logic             rst;
  logic             in_vld;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             full;
  logic             empty;
  logic             overflow;
`ifdef VALID_FIFO_DROP_CNT_EN
  logic [7:0]       drop_cnt;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  int unsigned      m_drop;

  valid_to_ready_fifo #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
`ifdef VALID_FIFO_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r_n, input bit vld, input logic [WIDTH-1:0] d, input bit rdy);
    bit p;
    bit f;
    if (!r_n) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      p = (q.size() > 0) && rdy;
      f = (q.size() == DEPTH);
      if (p) void'(q.pop_front());
      if (vld) begin
        if (!f || p) q.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
      end
    end
  endtask

  // Drive inputs, advance the model and the DUT by one clock, sample 1 time unit after the edge.
  task automatic step(input bit r_n, input bit vld, input logic [WIDTH-1:0] d, input bit rdy);
    rst     = r_n;
    in_vld  = vld;
    in_data = d;
    out_rdy = rdy;
    model_edge(r_n, vld, d, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".out_vld"}, 32'(out_vld), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
    check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef VALID_FIFO_DROP_CNT_EN
    check({tag, ".drop_cnt"}, 32'(drop_cnt), m_drop);
`endif
  endtask

  typedef struct {
    bit               vld;
    logic [WIDTH-1:0] data;
    bit               rdy;
    bit               e_vld;
    logic [WIDTH-1:0] e_data;
    bit               e_full;
    bit               e_empty;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] exp_out;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h4D, 1'b1, 1'b1, 8'h4D, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

    rst = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;

    // Reset held for 3 cycles with in_vld asserted
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
      check("rst.out_vld", 32'(out_vld), 32'd0);
      check("rst.empty", 32'(empty), 32'd1);
      check("rst.full", 32'(full), 32'd0);
      check("rst.overflow", 32'(overflow), 32'd0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check_model("post_rst");

    // Single transfer and handshake vectors
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].vld, vecs[i].data, vecs[i].rdy);
      check($sformatf("vec%0d.out_vld", i), 32'(out_vld), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(vecs[i].e_data));
      check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].e_empty));
    end

    // Fill to full, drop one, drain in order
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
    check("fill.full", 32'(full), 32'd1);
    check("fill.overflow", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, 8'h09, 1'b0);
    check("drop.overflow", 32'(overflow), 32'd1);
    check("drop.full", 32'(full), 32'd1);
`ifdef VALID_FIFO_DROP_CNT_EN
    check("drop.drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d.out_vld", i), 32'(out_vld), 32'd1);
      check($sformatf("drain%0d.out_data", i), 32'(out_data), 32'(i));
      step(1'b1, 1'b0, 8'h00, 1'b1);
    end
    check("drain.empty", 32'(empty), 32'd1);
    check("drain.out_vld", 32'(out_vld), 32'd0);

    // Full buffer with simultaneous push and pop
    step(1'b0, 1'b0, 8'h00, 1'b0);
    nxt = 8'h20;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, nxt, 1'b0);
      nxt++;
    end
    exp_out = 8'h20;
    for (int i = 0; i < 20; i++) begin
      check($sformatf("thru%0d.out_data", i), 32'(out_data), 32'(exp_out));
      step(1'b1, 1'b1, nxt, 1'b1);
      nxt++;
      exp_out++;
      check($sformatf("thru%0d.full", i), 32'(full), 32'd1);
      check($sformatf("thru%0d.overflow", i), 32'(overflow), 32'd0);
    end
    check_model("thru_end");

    // 300 drops while full, then a single reset cycle
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
    check_model("sat");
    check("sat.overflow", 32'(overflow), 32'd1);
`ifdef VALID_FIFO_DROP_CNT_EN
    check("sat.drop_cnt", 32'(drop_cnt), 32'd255);
`endif
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    check("sat_rst.overflow", 32'(overflow), 32'd0);
    check("sat_rst.empty", 32'(empty), 32'd1);
    check("sat_rst.out_vld", 32'(out_vld), 32'd0);
`ifdef VALID_FIFO_DROP_CNT_EN
    check("sat_rst.drop_cnt", 32'(drop_cnt), 32'd0);
`endif

    // Randomized traffic against the reference queue
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3));
      check_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
